dma_controller_multi: RTL and testbench

- Parametrised successor to the fixed 3-reader/1-writer DMA descriptor controller.
- Drives NUM_MM2S read-descriptor channels plus one S2MM write-descriptor channel, all from one PS-visible register file.
- Each channel runs its own FSM: independent start, valid held until ready, descriptor shadowed at start, status tracked per channel.
- Adds W1C done/error masks, a busy mask, S2MM tag sequencing and an optional interrupt.

---
 rtl/dma_controller_multi.sv | 212 +++++++++++++++++++++
 tb/tb_dma_controller_multi.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller_multi.sv
// Multi-channel DMA descriptor controller: NUM_MM2S readers plus one S2MM writer.
// Define DMA_IRQ_EN to enable the registered, maskable completion interrupt.
module dma_controller_multi #(
  parameter int NUM_MM2S        = 3,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_LEN_WIDTH   = 32,
  parameter int AXI_TAG_WIDTH   = 8,
  parameter int AXIS_USER_WIDTH = 65,
  parameter int REG_ADDR_WIDTH  = 8
) (
  input  logic                                             clk,
  input  logic                                             rstn,
  input  logic                                             reg_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0]                        reg_wr_addr,
  input  logic [AXI_DATA_WIDTH-1:0]                        reg_wr_data,
  input  logic [REG_ADDR_WIDTH-1:0]                        reg_rd_addr,
  output logic [AXI_DATA_WIDTH-1:0]                        reg_rd_data,
  output logic [NUM_MM2S*(AXI_ADDR_WIDTH+AXI_LEN_WIDTH)-1:0] mm2s_desc,
  output logic [NUM_MM2S*AXIS_USER_WIDTH-1:0]              mm2s_user,
  output logic [NUM_MM2S-1:0]                              mm2s_valid,
  input  logic [NUM_MM2S-1:0]                              mm2s_ready,
  input  logic [NUM_MM2S*4-1:0]                            mm2s_status_error,
  input  logic [NUM_MM2S-1:0]                              mm2s_status_valid,
  output logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0]          s2mm_desc,
  output logic [AXI_TAG_WIDTH-1:0]                         s2mm_tag,
  output logic                                             s2mm_valid,
  input  logic                                             s2mm_ready,
  input  logic [3:0]                                       s2mm_status_error,
  input  logic                                             s2mm_status_valid,
  output logic                                             irq
);

  localparam int NCH = NUM_MM2S + 1;
  localparam int DW  = AXI_ADDR_WIDTH + AXI_LEN_WIDTH;

  localparam logic [REG_ADDR_WIDTH-1:0] A_START = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] A_BUSY  = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] A_DONE  = REG_ADDR_WIDTH'(2);
  localparam logic [REG_ADDR_WIDTH-1:0] A_ERR   = REG_ADDR_WIDTH'(3);
  localparam logic [REG_ADDR_WIDTH-1:0] A_IRQEN = REG_ADDR_WIDTH'(4);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} st_t;

  function automatic logic [REG_ADDR_WIDTH-1:0] ch_reg(int c, int off);
    return REG_ADDR_WIDTH'(8 + 4 * c + off);
  endfunction

  st_t                        st       [NCH];
  logic [AXI_ADDR_WIDTH-1:0]  cfg_addr [NCH];
  logic [AXI_LEN_WIDTH-1:0]   cfg_len  [NCH];
  logic [AXI_DATA_WIDTH-1:0]  cfg_user [NCH];
  logic [AXI_ADDR_WIDTH-1:0]  sh_addr  [NCH];
  logic [AXI_LEN_WIDTH-1:0]   sh_len   [NCH];
  logic [AXIS_USER_WIDTH-1:0] sh_user  [NCH];
  logic [3:0]                 errcode  [NCH];

  logic [NCH-1:0]           valid_q;
  logic [NCH-1:0]           done_q;
  logic [NCH-1:0]           err_q;
  logic [NCH-1:0]           busy;
  logic [NCH-1:0]           irq_en;
  logic [AXI_TAG_WIDTH-1:0] tag_cnt;
  logic [AXI_TAG_WIDTH-1:0] tag_q;

  logic [NCH-1:0]   start_bits;
  logic [NCH-1:0]   w1c_done;
  logic [NCH-1:0]   w1c_err;
  logic [NCH-1:0]   done_set;
  logic [NCH-1:0]   err_set;
  logic [NCH-1:0]   rdy;
  logic [NCH-1:0]   st_valid;
  logic [4*NCH-1:0] st_err;

  assign rdy      = {s2mm_ready, mm2s_ready};
  assign st_valid = {s2mm_status_valid, mm2s_status_valid};
  assign st_err   = {s2mm_status_error, mm2s_status_error};

  always_comb begin
    start_bits = '0;
    w1c_done   = '0;
    w1c_err    = '0;
    if (reg_wr_en) begin
      unique case (1'b1)
        reg_wr_addr == A_START: start_bits = reg_wr_data[NCH-1:0];
        reg_wr_addr == A_DONE:  w1c_done   = reg_wr_data[NCH-1:0];
        reg_wr_addr == A_ERR:   w1c_err    = reg_wr_data[NCH-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    done_set = '0;
    err_set  = '0;
    busy     = '0;
    for (int c = 0; c < NCH; c++) begin
      busy[c] = (st[c] != S_IDLE);
      if (st[c] == S_WAIT && st_valid[c]) begin
        if (st_err[4*c +: 4] == 4'd0) done_set[c] = 1'b1;
        else                          err_set[c]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int c = 0; c < NCH; c++) begin
        st[c]       <= S_IDLE;
        cfg_addr[c] <= '0;
        cfg_len[c]  <= '0;
        cfg_user[c] <= '0;
        sh_addr[c]  <= '0;
        sh_len[c]   <= '0;
        sh_user[c]  <= '0;
        errcode[c]  <= '0;
      end
      valid_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      tag_cnt <= '0;
      tag_q   <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (reg_wr_en && reg_wr_addr == ch_reg(c, 0))
          cfg_addr[c] <= AXI_ADDR_WIDTH'(reg_wr_data);
        if (reg_wr_en && reg_wr_addr == ch_reg(c, 1))
          cfg_len[c] <= AXI_LEN_WIDTH'(reg_wr_data);
        if (reg_wr_en && reg_wr_addr == ch_reg(c, 2))
          cfg_user[c] <= reg_wr_data;
        unique case (st[c])
          S_IDLE: if (start_bits[c]) begin
            st[c]      <= S_REQ;
            valid_q[c] <= 1'b1;
            sh_addr[c] <= cfg_addr[c];
            sh_len[c]  <= cfg_len[c];
            sh_user[c] <= AXIS_USER_WIDTH'(cfg_user[c]);
          end
          S_REQ: if (rdy[c]) begin
            st[c]      <= S_WAIT;
            valid_q[c] <= 1'b0;
          end
          S_WAIT: if (st_valid[c]) begin
            st[c]      <= S_IDLE;
            errcode[c] <= st_err[4*c +: 4];
          end
          default: begin
            st[c]      <= S_IDLE;
            valid_q[c] <= 1'b0;
          end
        endcase
      end
      // hardware set beats a same-cycle W1C
      done_q <= (done_q & ~w1c_done) | done_set;
      err_q  <= (err_q & ~w1c_err) | err_set;
      if (start_bits[NUM_MM2S] && st[NUM_MM2S] == S_IDLE) begin
        tag_q   <= tag_cnt;
        tag_cnt <= tag_cnt + 1'b1;
      end
    end
  end

`ifdef DMA_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      irq_en <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (reg_wr_en && reg_wr_addr == A_IRQEN)
        irq_en <= reg_wr_data[NCH-1:0];
      irq_q <= |((done_q | err_q) & irq_en);
    end
  end
  assign irq = irq_q;
`else
  assign irq_en = '0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    reg_rd_data = '0;
    unique case (1'b1)
      reg_rd_addr == A_BUSY:  reg_rd_data = AXI_DATA_WIDTH'(busy);
      reg_rd_addr == A_DONE:  reg_rd_data = AXI_DATA_WIDTH'(done_q);
      reg_rd_addr == A_ERR:   reg_rd_data = AXI_DATA_WIDTH'(err_q);
      reg_rd_addr == A_IRQEN: reg_rd_data = AXI_DATA_WIDTH'(irq_en);
      default: ;
    endcase
    for (int c = 0; c < NCH; c++) begin
      if (reg_rd_addr == ch_reg(c, 0))
        reg_rd_data = AXI_DATA_WIDTH'(cfg_addr[c]);
      if (reg_rd_addr == ch_reg(c, 1))
        reg_rd_data = AXI_DATA_WIDTH'(cfg_len[c]);
      if (reg_rd_addr == ch_reg(c, 2))
        reg_rd_data = cfg_user[c];
      if (reg_rd_addr == ch_reg(c, 3))
        reg_rd_data = AXI_DATA_WIDTH'(errcode[c]);
    end
  end

  for (genvar c = 0; c < NUM_MM2S; c++) begin : g_mm2s
    assign mm2s_desc[c*DW +: DW] = {sh_len[c], sh_addr[c]};
    assign mm2s_user[c*AXIS_USER_WIDTH +: AXIS_USER_WIDTH] = sh_user[c];
  end

  assign mm2s_valid = valid_q[NUM_MM2S-1:0];
  assign s2mm_valid = valid_q[NUM_MM2S];
  assign s2mm_desc  = {sh_len[NUM_MM2S], sh_addr[NUM_MM2S]};
  assign s2mm_tag   = tag_q;

endmodule

// File: tb/tb_dma_controller_multi.sv
// Bench for dma_controller_multi: register vector table, descriptor
// scoreboard and hand-written multi-cycle sequences.
module tb_dma_controller_multi;

  localparam int NM  = 3;
  localparam int NCH = NM + 1;
  localparam int AW  = 32;
  localparam int LW  = 32;
  localparam int DW  = 32;
  localparam int TW  = 8;
  localparam int UW  = 65;
  localparam int RW  = 8;

`ifdef DMA_IRQ_EN
  localparam logic [31:0] IRQ_RB = 32'h1;
`else
  localparam logic [31:0] IRQ_RB = 32'h0;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              reg_wr_en = 1'b0;
  logic [RW-1:0]     reg_wr_addr = '0;
  logic [DW-1:0]     reg_wr_data = '0;
  logic [RW-1:0]     reg_rd_addr = '0;
  logic [DW-1:0]     reg_rd_data;
  logic [NM*(AW+LW)-1:0] mm2s_desc;
  logic [NM*UW-1:0]  mm2s_user;
  logic [NM-1:0]     mm2s_valid;
  logic [NM-1:0]     mm2s_ready = '0;
  logic [NM*4-1:0]   mm2s_status_error = '0;
  logic [NM-1:0]     mm2s_status_valid = '0;
  logic [AW+LW-1:0]  s2mm_desc;
  logic [TW-1:0]     s2mm_tag;
  logic              s2mm_valid;
  logic              s2mm_ready = 1'b0;
  logic [3:0]        s2mm_status_error = '0;
  logic              s2mm_status_valid = 1'b0;
  logic              irq;

  dma_controller_multi #(
    .NUM_MM2S(NM), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .AXI_LEN_WIDTH(LW), .AXI_TAG_WIDTH(TW),
    .AXIS_USER_WIDTH(UW), .REG_ADDR_WIDTH(RW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data),
    .mm2s_desc(mm2s_desc), .mm2s_user(mm2s_user),
    .mm2s_valid(mm2s_valid), .mm2s_ready(mm2s_ready),
    .mm2s_status_error(mm2s_status_error),
    .mm2s_status_valid(mm2s_status_valid),
    .s2mm_desc(s2mm_desc), .s2mm_tag(s2mm_tag),
    .s2mm_valid(s2mm_valid), .s2mm_ready(s2mm_ready),
    .s2mm_status_error(s2mm_status_error),
    .s2mm_status_valid(s2mm_status_valid),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int             ch;
    logic [LW-1:0]  len;
    logic [AW-1:0]  addr;
    logic [UW-1:0]  user;
    logic [TW-1:0]  tag;
  } exp_t;

  typedef struct {
    logic [RW-1:0] wa;
    logic [DW-1:0] wd;
    logic [RW-1:0] ra;
    logic [DW-1:0] re;
  } vec_t;

  exp_t           sbq[$];
  int             hs_cnt[NCH];
  logic [AW-1:0]  m_addr[NCH];
  logic [LW-1:0]  m_len[NCH];
  logic [DW-1:0]  m_user[NCH];
  logic [TW-1:0]  m_tag = '0;
  logic [NCH-1:0] m_busy = '0;
  vec_t           tbl[12];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(logic [RW-1:0] a, logic [DW-1:0] d);
    @(negedge clk);
    reg_wr_en = 1'b1;
    reg_wr_addr = a;
    reg_wr_data = d;
    @(negedge clk);
    reg_wr_en = 1'b0;
  endtask

  task automatic rd_chk(string name, logic [RW-1:0] a, logic [DW-1:0] e);
    reg_rd_addr = a;
    #1;
    chk(name, reg_rd_data, e);
  endtask

  task automatic cfg(int c, logic [AW-1:0] a, logic [LW-1:0] l,
                     logic [DW-1:0] u);
    wr(RW'(8 + 4 * c), a);
    wr(RW'(9 + 4 * c), l);
    wr(RW'(10 + 4 * c), u);
    m_addr[c] = a;
    m_len[c]  = l;
    m_user[c] = u;
  endtask

  task automatic start(logic [NCH-1:0] mask);
    for (int c = 0; c < NCH; c++) begin
      if (mask[c] && !m_busy[c]) begin
        exp_t e;
        e.ch   = c;
        e.len  = m_len[c];
        e.addr = m_addr[c];
        e.user = (c < NM) ? UW'(m_user[c]) : '0;
        e.tag  = (c == NM) ? m_tag : '0;
        if (c == NM) m_tag = m_tag + 1'b1;
        m_busy[c] = 1'b1;
        sbq.push_back(e);
      end
    end
    wr(RW'(0), DW'(mask));
  endtask

  task automatic status(logic [NCH-1:0] mask, logic [3:0] em,
                        logic [3:0] es);
    @(negedge clk);
    mm2s_status_valid = mask[NM-1:0];
    s2mm_status_valid = mask[NM];
    for (int c = 0; c < NM; c++) mm2s_status_error[c*4 +: 4] = em;
    s2mm_status_error = es;
    @(negedge clk);
    mm2s_status_valid = '0;
    s2mm_status_valid = 1'b0;
    mm2s_status_error = '0;
    s2mm_status_error = '0;
    m_busy = m_busy & ~mask;
  endtask

  // Descriptor scoreboard: every accepted handshake must match the
  // oldest expectation queued for that channel.
  logic [NCH-1:0] hv;
  always @(negedge clk) begin
    #2;
    hv = {s2mm_valid & s2mm_ready, mm2s_valid & mm2s_ready};
    if (rstn) begin
      for (int c = 0; c < NCH; c++) begin
        if (hv[c]) begin
          int idx;
          logic [AW+LW-1:0] got;
          idx = -1;
          hs_cnt[c]++;
          for (int i = 0; i < sbq.size(); i++)
            if (sbq[i].ch == c && idx < 0) idx = i;
          got = (c < NM) ? mm2s_desc[c*(AW+LW) +: AW+LW] : s2mm_desc;
          if (idx < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL hs_unexpected ch%0d: got handshake required none", c);
          end else begin
            chk($sformatf("hs_desc_ch%0d", c), 128'(got),
                128'({sbq[idx].len, sbq[idx].addr}));
            if (c < NM)
              chk($sformatf("hs_user_ch%0d", c),
                  128'(mm2s_user[c*UW +: UW]), 128'(sbq[idx].user));
            else
              chk("hs_tag", 128'(s2mm_tag), 128'(sbq[idx].tag));
            sbq.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    int hs_before;
    for (int c = 0; c < NCH; c++) begin
      hs_cnt[c] = 0;
      m_addr[c] = '0;
      m_len[c]  = '0;
      m_user[c] = '0;
    end
    tbl[0]  = '{8'h09, 32'h40,   8'h09, 32'h40};
    tbl[1]  = '{8'h08, 32'h1000, 8'h08, 32'h1000};
    tbl[2]  = '{8'h0A, 32'h5,    8'h0A, 32'h5};
    tbl[3]  = '{8'h14, 32'hABCD, 8'h14, 32'hABCD};
    tbl[4]  = '{8'h16, 32'h77,   8'h16, 32'h77};
    tbl[5]  = '{8'h05, 32'hFFFF, 8'h05, 32'h0};
    tbl[6]  = '{8'h00, 32'h0,    8'h00, 32'h0};
    tbl[7]  = '{8'h0B, 32'h9,    8'h0B, 32'h0};
    tbl[8]  = '{8'h01, 32'hF,    8'h01, 32'h0};
    tbl[9]  = '{8'h20, 32'h55,   8'h20, 32'h0};
    tbl[10] = '{8'h04, 32'h1,    8'h04, IRQ_RB};
    tbl[11] = '{8'h04, 32'h0,    8'h04, 32'h0};

    repeat (3) @(negedge clk);
    chk("rst_mm2s_valid", 128'(mm2s_valid), 0);
    chk("rst_s2mm_valid", 128'(s2mm_valid), 0);
    chk("rst_irq", 128'(irq), 0);
    chk("rst_desc", 128'(mm2s_desc[63:0]), 0);
    rd_chk("rst_busy", 8'h01, 0);
    rd_chk("rst_done", 8'h02, 0);
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      wr(tbl[i].wa, tbl[i].wd);
      rd_chk($sformatf("reg_vec%0d", i), tbl[i].ra, tbl[i].re);
    end

    // ch0 with ready held low for three cycles
    cfg(0, 32'h1000, 32'd64, 32'd5);
    start(4'h1);
    for (int i = 0; i < 3; i++) begin
      chk("t1_valid_hold", 128'(mm2s_valid[0]), 1);
      chk("t1_desc_stable", 128'(mm2s_desc[63:0]), 128'({32'd64, 32'h1000}));
      @(negedge clk);
    end
    chk("t1_valid_4th", 128'(mm2s_valid[0]), 1);
    rd_chk("t1_busy", 8'h01, 32'h1);
    mm2s_ready[0] = 1'b1;
    @(negedge clk);
    mm2s_ready[0] = 1'b0;
    chk("t1_valid_drop", 128'(mm2s_valid[0]), 0);
    rd_chk("t1_busy_wait", 8'h01, 32'h1);
    status(4'h1, 4'h0, 4'h0);
    rd_chk("t1_busy_clr", 8'h01, 32'h0);
    rd_chk("t1_done", 8'h02, 32'h1);
    wr(8'h02, 32'h1);
    rd_chk("t1_done_w1c", 8'h02, 32'h0);

    // all four channels at once, ready high
    cfg(1, 32'h2100, 32'd32, 32'd1);
    cfg(2, 32'h2200, 32'd48, 32'd2);
    cfg(3, 32'h2300, 32'd80, 32'd0);
    @(negedge clk);
    mm2s_ready = 3'b111;
    s2mm_ready = 1'b1;
    start(4'hF);
    chk("t2_valid_on", 128'({s2mm_valid, mm2s_valid}), 128'(4'hF));
    @(negedge clk);
    chk("t2_valid_off", 128'({s2mm_valid, mm2s_valid}), 0);
    mm2s_ready = '0;
    s2mm_ready = 1'b0;
    rd_chk("t2_busy", 8'h01, 32'hF);
    status(4'hF, 4'h0, 4'h3);
    rd_chk("t2_done", 8'h02, 32'h7);
    rd_chk("t2_error", 8'h03, 32'h8);
    rd_chk("t2_errcode3", 8'h17, 32'h3);
    rd_chk("t2_errcode0", 8'h0B, 32'h0);
    wr(8'h03, 32'h8);
    rd_chk("t2_error_w1c", 8'h03, 32'h0);
    wr(8'h02, 32'h7);

    // config rewrite during REQ, restart during WAIT
    cfg(1, 32'h2000, 32'd16, 32'd7);
    hs_before = hs_cnt[1];
    start(4'h2);
    chk("t3_valid", 128'(mm2s_valid[1]), 1);
    wr(8'h0C, 32'h3333);
    m_addr[1] = 32'h3333;
    chk("t3_desc_shadow", 128'(mm2s_desc[64 +: 64]), 128'({32'd16, 32'h2000}));
    mm2s_ready[1] = 1'b1;
    @(negedge clk);
    mm2s_ready[1] = 1'b0;
    start(4'h2);
    chk("t3_restart_valid", 128'(mm2s_valid[1]), 0);
    @(negedge clk);
    chk("t3_restart_valid2", 128'(mm2s_valid[1]), 0);
    rd_chk("t3_busy", 8'h01, 32'h2);
    status(4'h2, 4'h0, 4'h0);
    chk("t3_one_hs", 128'(hs_cnt[1] - hs_before), 1);
    rd_chk("t3_busy_clr", 8'h01, 32'h0);
    rd_chk("t3_done", 8'h02, 32'h2);
    rd_chk("t3_addr_rb", 8'h0C, 32'h3333);

    // reset while ch2 is requesting
    cfg(2, 32'h4000, 32'd128, 32'd9);
    start(4'h4);
    chk("t5_valid_pre", 128'(mm2s_valid[2]), 1);
    rstn = 1'b0;
    @(negedge clk);
    sbq.delete();
    m_busy = '0;
    m_tag  = '0;
    for (int c = 0; c < NCH; c++) begin
      m_addr[c] = '0;
      m_len[c]  = '0;
      m_user[c] = '0;
    end
    chk("t5_valid_rst", 128'(mm2s_valid), 0);
    chk("t5_desc_rst", 128'(mm2s_desc), 0);
    rd_chk("t5_busy_rst", 8'h01, 0);
    rd_chk("t5_done_rst", 8'h02, 0);
    rd_chk("t5_addr_rst", 8'h08, 0);
    rd_chk("t5_user_rst", 8'h12, 0);
    rstn = 1'b1;
    status(4'h4, 4'h0, 4'h0);
    rd_chk("t5_late_done", 8'h02, 0);
    rd_chk("t5_late_busy", 8'h01, 0);

    // tag sequencing across wrap
    cfg(3, 32'h5000, 32'd256, 32'd0);
    @(negedge clk);
    s2mm_ready = 1'b1;
    for (int j = 0; j < 257; j++) begin
      start(4'h8);
      status(4'h8, 4'h0, 4'h0);
    end
    s2mm_ready = 1'b0;
    chk("t4_tag_wrap", 128'(s2mm_tag), 0);
    chk("t4_hs_count", 128'(hs_cnt[3]), 258);
    wr(8'h02, 32'h8);

    // interrupt and set-vs-W1C collision on ch0
    wr(8'h04, 32'h1);
    rd_chk("t6_irqen_rb", 8'h04, IRQ_RB);
    cfg(0, 32'h6000, 32'd8, 32'd3);
    @(negedge clk);
    mm2s_ready[0] = 1'b1;
    start(4'h1);
    @(negedge clk);
    status(4'h1, 4'h0, 4'h0);
    rd_chk("t6_done", 8'h02, 32'h1);
    chk("t6_irq_lag", 128'(irq), 0);
    @(negedge clk);
    chk("t6_irq_on", 128'(irq), 128'(IRQ_RB[0]));
    start(4'h1);
    @(negedge clk);
    @(negedge clk);
    reg_wr_en = 1'b1;
    reg_wr_addr = 8'h02;
    reg_wr_data = 32'h1;
    mm2s_status_valid[0] = 1'b1;
    @(negedge clk);
    reg_wr_en = 1'b0;
    mm2s_status_valid[0] = 1'b0;
    m_busy[0] = 1'b0;
    mm2s_ready[0] = 1'b0;
    rd_chk("t6_set_wins", 8'h02, 32'h1);
    wr(8'h02, 32'h1);
    rd_chk("t6_done_clr", 8'h02, 32'h0);
    chk("t6_irq_hold", 128'(irq), 128'(IRQ_RB[0]));
    @(negedge clk);
    chk("t6_irq_off", 128'(irq), 0);

    chk("sb_empty", 128'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
